// File: rtl/elevator_call_latch_if.sv
// Button, door/floor feedback and call-lamp bundle between the elevator
// controller and its call latch stage.
interface elevator_call_latch_if;
  logic i_btn_h1_up;
  logic i_btn_h2_up;
  logic i_btn_h2_dn;
  logic i_btn_h3_dn;
  logic i_btn_c1;
  logic i_btn_c2;
  logic i_btn_c3;
  logic i_open;
  logic i_floor_r;
  logic i_floor_g;
  logic i_floor_b;
  logic i_dir_up;
  logic i_dir_dn;
  logic o_led0;
  logic o_led1;
  logic o_led2;
  logic o_led3;
  logic o_led6;
  logic o_led7;
  logic o_led8;
  logic o_call_pending;

  modport master (
    output i_btn_h1_up, i_btn_h2_up, i_btn_h2_dn, i_btn_h3_dn,
    output i_btn_c1, i_btn_c2, i_btn_c3,
    output i_open, i_floor_r, i_floor_g, i_floor_b, i_dir_up, i_dir_dn,
    input  o_led0, o_led1, o_led2, o_led3, o_led6, o_led7, o_led8,
    input  o_call_pending
  );

  modport slave (
    input  i_btn_h1_up, i_btn_h2_up, i_btn_h2_dn, i_btn_h3_dn,
    input  i_btn_c1, i_btn_c2, i_btn_c3,
    input  i_open, i_floor_r, i_floor_g, i_floor_b, i_dir_up, i_dir_dn,
    output o_led0, o_led1, o_led2, o_led3, o_led6, o_led7, o_led8,
    output o_call_pending
  );
endinterface

// File: rtl/elevator_call_latch.sv
// Synchronises and debounces seven call buttons, latches presses into lamps and
// clears lamps when the car is at the floor with its door open.
module elevator_call_latch #(
  parameter int unsigned DEBOUNCE = 16,
  parameter int unsigned CNT_W    = 16
) (
  input logic                  clk,
  input logic                  rst,
  elevator_call_latch_if.slave bus
);

  localparam int unsigned NCH = 7;

  // Channel order: h1_up, h2_up, h2_dn, h3_dn, c1, c2, c3 (lamps 0,1,2,3,6,7,8)
  logic [NCH-1:0] w_btn;
  logic [NCH-1:0] w_set;
  logic [NCH-1:0] w_clr;
  logic           w_floor_valid;

  logic [NCH-1:0] r_s1;
  logic [NCH-1:0] r_s2;
  logic [NCH-1:0] r_deb;
  logic [NCH-1:0] r_deb_d;
  logic [NCH-1:0] r_latch;
  logic [CNT_W-1:0] r_cnt [NCH];
  logic           r_pending;

  assign w_btn = {bus.i_btn_c3, bus.i_btn_c2, bus.i_btn_c1, bus.i_btn_h3_dn,
                  bus.i_btn_h2_dn, bus.i_btn_h2_up, bus.i_btn_h1_up};

  assign w_set = r_deb & ~r_deb_d;

  always_comb begin
    w_floor_valid = 1'b0;
    case ({bus.i_floor_r, bus.i_floor_g, bus.i_floor_b})
      3'b100, 3'b010, 3'b001: w_floor_valid = 1'b1;
      default:                w_floor_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_clr = '0;
    if (bus.i_open && w_floor_valid) begin
      if (bus.i_floor_r) begin
        w_clr[0] = 1'b1;
        w_clr[4] = 1'b1;
      end
      if (bus.i_floor_g) begin
        w_clr[5] = 1'b1;
        // Middle floor: only the hall call matching travel direction, both when idle
        if (bus.i_dir_up && !bus.i_dir_dn) begin
          w_clr[1] = 1'b1;
        end else if (bus.i_dir_dn && !bus.i_dir_up) begin
          w_clr[2] = 1'b1;
        end else begin
          w_clr[1] = 1'b1;
          w_clr[2] = 1'b1;
        end
      end
      if (bus.i_floor_b) begin
        w_clr[3] = 1'b1;
        w_clr[6] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_deb     <= '0;
      r_deb_d   <= '0;
      r_latch   <= '0;
      r_pending <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1    <= w_btn;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      for (int i = 0; i < NCH; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DEBOUNCE - 1)) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      // Clear beats set so a press at the open, serviced floor is ignored
      r_latch   <= (r_latch | w_set) & ~w_clr;
      r_pending <= |r_latch;
    end
  end

  assign bus.o_led0         = r_latch[0];
  assign bus.o_led1         = r_latch[1];
  assign bus.o_led2         = r_latch[2];
  assign bus.o_led3         = r_latch[3];
  assign bus.o_led6         = r_latch[4];
  assign bus.o_led7         = r_latch[5];
  assign bus.o_led8         = r_latch[6];
  assign bus.o_call_pending = r_pending;

endmodule

// File: tb/tb_elevator_call_latch.sv
// Directed and random stimulus for elevator_call_latch, checked every cycle
// against a sliding-window reference model of the button channels.
module tb_elevator_call_latch;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] t_btn = '0;
  logic t_open = 1'b0;
  logic [2:0] t_floor = '0;   // {r, g, b}
  logic [1:0] t_dir = '0;     // {up, dn}

  int n_checks = 0;
  int n_errors = 0;

  // Model: raw samples per edge (index 0 newest), debounced level, lamps
  logic [6:0] m_raw [0:DEB];
  logic [6:0] m_deb;
  logic [6:0] m_deb_prev;
  logic [6:0] m_latch;
  logic       m_pend;

  elevator_call_latch_if bus();

  elevator_call_latch #(.DEBOUNCE(DEB), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.i_btn_h1_up = t_btn[0];
  assign bus.i_btn_h2_up = t_btn[1];
  assign bus.i_btn_h2_dn = t_btn[2];
  assign bus.i_btn_h3_dn = t_btn[3];
  assign bus.i_btn_c1    = t_btn[4];
  assign bus.i_btn_c2    = t_btn[5];
  assign bus.i_btn_c3    = t_btn[6];
  assign bus.i_open      = t_open;
  assign bus.i_floor_r   = t_floor[2];
  assign bus.i_floor_g   = t_floor[1];
  assign bus.i_floor_b   = t_floor[0];
  assign bus.i_dir_up    = t_dir[1];
  assign bus.i_dir_dn    = t_dir[0];

  logic [6:0] w_leds;
  assign w_leds = {bus.o_led8, bus.o_led7, bus.o_led6, bus.o_led3,
                   bus.o_led2, bus.o_led1, bus.o_led0};

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [6:0] clr;
    logic [6:0] nxt_deb;
    int nfl;
    if (rst) begin
      for (int j = 0; j <= DEB; j++) m_raw[j] = '0;
      m_deb = '0;
      m_deb_prev = '0;
      m_latch = '0;
      m_pend = 1'b0;
    end else begin
      clr = '0;
      nfl = int'(t_floor[2]) + int'(t_floor[1]) + int'(t_floor[0]);
      if (t_open && nfl == 1) begin
        if (t_floor[2]) clr = 7'b001_0001;
        if (t_floor[0]) clr = 7'b100_1000;
        if (t_floor[1]) begin
          clr = 7'b010_0000;
          if (t_dir == 2'b10)      clr = clr | 7'b000_0010;
          else if (t_dir == 2'b01) clr = clr | 7'b000_0100;
          else                     clr = clr | 7'b000_0110;
        end
      end
      // Debounced level flips once the last DEB synchronised samples all disagree
      nxt_deb = m_deb;
      for (int c = 0; c < 7; c++) begin
        bit all_diff = 1'b1;
        for (int j = 1; j <= DEB; j++)
          if (m_raw[j][c] == m_deb[c]) all_diff = 1'b0;
        if (all_diff) nxt_deb[c] = ~m_deb[c];
      end
      m_pend = |m_latch;
      m_latch = (m_latch | (m_deb & ~m_deb_prev)) & ~clr;
      m_deb_prev = m_deb;
      m_deb = nxt_deb;
      for (int j = DEB; j >= 1; j--) m_raw[j] = m_raw[j-1];
      m_raw[0] = t_btn;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_val("leds", 32'(w_leds), 32'(m_latch));
      check_val("pend", 32'(bus.o_call_pending), 32'(m_pend));
    end
  endtask

  initial begin
    for (int j = 0; j <= DEB; j++) m_raw[j] = '0;
    m_deb = '0; m_deb_prev = '0; m_latch = '0; m_pend = 1'b0;

    #2;
    rst = 1'b1;
    run(1);
    check_val("rst_leds", 32'(w_leds), 0);
    check_val("rst_pend", 32'(bus.o_call_pending), 0);
    rst = 1'b0;

    // Car call 2: lamp six edges after first sampled edge, pending one later
    t_btn[5] = 1'b1;
    run(6);
    check_val("c2_early", 32'(w_leds[5]), 0);
    run(1);
    check_val("c2_led7", 32'(w_leds[5]), 1);
    check_val("c2_pend_lag", 32'(bus.o_call_pending), 0);
    run(1);
    check_val("c2_pend", 32'(bus.o_call_pending), 1);
    check_val("c2_others", 32'(w_leds & 7'b101_1111), 0);
    t_btn[5] = 1'b0;
    run(4);

    for (int r = 0; r < 5; r++) begin
      t_btn[0] = 1'b1; run(3);
      t_btn[0] = 1'b0; run(3);
    end
    run(4);
    check_val("glitch_led0", 32'(w_leds[0]), 0);

    t_btn[1] = 1'b1; t_btn[2] = 1'b1; run(8);
    t_btn[1] = 1'b0; t_btn[2] = 1'b0; run(8);
    t_floor = 3'b010; t_dir = 2'b10; t_open = 1'b1;
    run(1);
    check_val("g_up_led1", 32'(w_leds[1]), 0);
    check_val("g_up_led7", 32'(w_leds[5]), 0);
    check_val("g_up_led2", 32'(w_leds[2]), 1);
    check_val("g_up_pend", 32'(bus.o_call_pending), 1);
    t_floor = 3'b000; t_dir = 2'b00; t_open = 1'b0;
    run(2);
    check_val("g_up_pend2", 32'(bus.o_call_pending), 1);

    t_floor = 3'b001; t_open = 1'b1;
    t_btn[3] = 1'b1; run(10);
    t_btn[3] = 1'b0; run(6);
    check_val("b_open_led3", 32'(w_leds[3]), 0);
    t_floor = 3'b000; t_open = 1'b0;
    t_btn[3] = 1'b1; run(10);
    check_val("b_closed_led3", 32'(w_leds[3]), 1);
    t_btn[3] = 1'b0; run(6);

    t_btn[0] = 1'b1; run(10);
    t_btn[0] = 1'b0; run(6);
    t_floor = 3'b110; t_open = 1'b1;
    run(3);
    check_val("invalid_led0", 32'(w_leds[0]), 1);
    t_floor = 3'b000; t_open = 1'b0;

    t_btn = 7'h7f; run(10);
    t_btn = 7'h00; run(8);
    check_val("all_latched", 32'(w_leds), 32'h7f);
    t_btn[4] = 1'b1; run(3);
    rst = 1'b1; run(1);
    check_val("mid_rst_leds", 32'(w_leds), 0);
    check_val("mid_rst_pend", 32'(bus.o_call_pending), 0);
    rst = 1'b0; t_btn[4] = 1'b0;
    run(10);
    check_val("mid_rst_led6", 32'(w_leds[4]), 0);

    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 7; c++)
        if ($urandom_range(0, 7) == 0) t_btn[c] = ~t_btn[c];
      if ($urandom_range(0, 4) == 0) t_floor = 3'($urandom_range(0, 7));
      else t_floor = 3'(1 << $urandom_range(0, 2));
      t_open = ($urandom_range(0, 3) == 0);
      t_dir = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      run(1);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
